// File: rtl/rx_frame_ctrl.sv
// RX frame controller: releases the AGC, waits for it to settle, searches for a correlator
// peak, captures a fixed-length payload into the DMA packet buffer and holds it until acked.
module rx_frame_ctrl #(
  parameter int unsigned SETTLE_LEN  = 256,
  parameter int unsigned PAYLOAD_LEN = 128,
  parameter int unsigned TIMEOUT_LEN = 4096,
  parameter int unsigned AW          = 8
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_en,
  input  logic [15:0]   i_in_i,
  input  logic [15:0]   i_in_q,
  input  logic          i_in_vld,
  input  logic          i_max_vld,
  input  logic          i_frame_ack,
  output logic          o_agc_rst,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [31:0]   o_wr_data,
  output logic          o_frame_rdy,
  output logic [2:0]    o_state,
  output logic [15:0]   o_drop_cnt
);

  localparam int unsigned MAX_SP  = (SETTLE_LEN > PAYLOAD_LEN) ? SETTLE_LEN : PAYLOAD_LEN;
  localparam int unsigned MAX_LEN = (TIMEOUT_LEN > MAX_SP) ? TIMEOUT_LEN : MAX_SP;
  localparam int unsigned CW      = $clog2(MAX_LEN) + 1;
  localparam int unsigned DW      = 32;
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    SEARCH  = 3'd2,
    CAPTURE = 3'd3,
    READY   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          timeout_hit;

  logic          agc_rst_nxt;
  logic          wr_en_nxt;
  logic [AW-1:0] wr_addr_nxt;
  logic [DW-1:0] wr_data_nxt;
  logic          frame_rdy_nxt;
  logic [15:0]   drop_cnt_nxt;

  // State and shared sample counter
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state; dropping i_en overrides every other transition
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timeout_hit = 1'b0;
    if (!i_en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
        SETTLE: begin
          if (i_in_vld) begin
            if (cnt == CW'(SETTLE_LEN - 1)) begin
              state_nxt = SEARCH;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
        end
        SEARCH: begin
          if (i_max_vld) begin
            state_nxt = CAPTURE;
            cnt_nxt   = '0;
          end else if (i_in_vld) begin
            if (cnt == CW'(TIMEOUT_LEN - 1)) begin
              state_nxt   = SETTLE;
              cnt_nxt     = '0;
              timeout_hit = 1'b1;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
        end
        CAPTURE: begin
          if (i_in_vld) begin
            if (cnt == CW'(PAYLOAD_LEN - 1)) begin
              state_nxt = READY;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
        end
        READY: begin
          if (i_frame_ack) begin
            state_nxt = SEARCH;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Next values of the registered outputs
  always_comb begin
    agc_rst_nxt   = (state_nxt == IDLE);
    wr_en_nxt     = i_en && (state == CAPTURE) && i_in_vld;
    wr_addr_nxt   = o_wr_addr;
    wr_data_nxt   = o_wr_data;
    frame_rdy_nxt = (state == READY) && (state_nxt == READY);
    drop_cnt_nxt  = o_drop_cnt;
    if (wr_en_nxt) begin
      wr_addr_nxt = AW'(cnt);
      wr_data_nxt = {i_in_q, i_in_i};
    end
    if (timeout_hit && (o_drop_cnt != DROP_MAX)) begin
      drop_cnt_nxt = o_drop_cnt + 16'd1;
    end
  end

  // Output registers; address/data hold their last value between writes
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_agc_rst   <= 1'b1;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_frame_rdy <= 1'b0;
      o_drop_cnt  <= '0;
    end else begin
      o_agc_rst   <= agc_rst_nxt;
      o_wr_en     <= wr_en_nxt;
      o_wr_addr   <= wr_addr_nxt;
      o_wr_data   <= wr_data_nxt;
      o_frame_rdy <= frame_rdy_nxt;
      o_drop_cnt  <= drop_cnt_nxt;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl: scenario tasks plus a write scoreboard that
// checks address, data and one-cycle write latency of every buffer write.
module tb_rx_frame_ctrl;

  localparam int unsigned AW = 3;

  logic          clk;
  logic          rstn;
  logic          en;
  logic [15:0]   in_i;
  logic [15:0]   in_q;
  logic          in_vld;
  logic          max_vld;
  logic          frame_ack;
  logic          agc_rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          frame_rdy;
  logic [2:0]    state;
  logic [15:0]   drop_cnt;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          waddr = 0;
  int          n_wr  = 0;
  logic [15:0] smp   = 16'd1;

  rx_frame_ctrl #(
    .SETTLE_LEN (4),
    .PAYLOAD_LEN(8),
    .TIMEOUT_LEN(16),
    .AW         (AW)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_en       (en),
    .i_in_i     (in_i),
    .i_in_q     (in_q),
    .i_in_vld   (in_vld),
    .i_max_vld  (max_vld),
    .i_frame_ack(frame_ack),
    .o_agc_rst  (agc_rst),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_frame_rdy(frame_rdy),
    .o_state    (state),
    .o_drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 100000", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance one clock and score any buffer write against the expected queue
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (rstn && wr_en) begin
      n_wr++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected: addr=%0d data=%h cyc=%0d, required no write", wr_addr, wr_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL wr_check: addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  // Drive one cycle of inputs; cap=1 means this valid sample must be written
  task automatic send(input logic vld, input logic mx, input logic ack, input logic cap);
    exp_t e;
    in_vld    = vld;
    max_vld   = mx;
    frame_ack = ack;
    in_i      = smp;
    in_q      = 16'd0 - smp;
    if (cap && vld) begin
      e.addr = AW'(waddr);
      e.data = {16'd0 - smp, smp};
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
      waddr++;
    end
    tick();
    if (vld) smp++;
    in_vld    = 1'b0;
    max_vld   = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1; en = 1'b0; in_vld = 1'b0; max_vld = 1'b0; frame_ack = 1'b0;
    in_i = '0; in_q = '0;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (state !== 3'd0)   begin n_bad++; $display("FAIL rst_state: got %0d required 0", state); end
    n_cmp++; if (agc_rst !== 1'b1) begin n_bad++; $display("FAIL rst_agc: got %b required 1", agc_rst); end
    n_cmp++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
      n_bad++; $display("FAIL rst_wr: got en=%b addr=%0d data=%h required 0/0/0", wr_en, wr_addr, wr_data);
    end
    n_cmp++; if (frame_rdy !== 1'b0 || drop_cnt !== 16'd0) begin
      n_bad++; $display("FAIL rst_misc: got rdy=%b drop=%0d required 0/0", frame_rdy, drop_cnt);
    end
    rstn = 1'b1;
    tick(); tick();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL idle_hold: got %0d required 0", state); end
  endtask

  task automatic test_nominal();
    en = 1'b1;
    send(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (state !== 3'd1 || agc_rst !== 1'b0) begin
      n_bad++; $display("FAIL nom_settle: got state=%0d agc=%b required 1/0", state, agc_rst);
    end
    repeat (3) send(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL nom_settle3: got %0d required 1", state); end
    send(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL nom_search: got %0d required 2", state); end
    repeat (4) send(1'b1, 1'b0, 1'b0, 1'b0);
    waddr = 0;
    send(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL nom_capture: got %0d required 3", state); end
    repeat (8) send(1'b1, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (state !== 3'd4 || frame_rdy !== 1'b0) begin
      n_bad++; $display("FAIL nom_last_wr: got state=%0d rdy=%b required 4/0", state, frame_rdy);
    end
    send(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (frame_rdy !== 1'b1) begin n_bad++; $display("FAIL nom_rdy: got %b required 1", frame_rdy); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL nom_missing: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_handoff();
    repeat (3) send(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (frame_rdy !== 1'b1 || state !== 3'd4) begin
      n_bad++; $display("FAIL hand_hold: got state=%0d rdy=%b required 4/1", state, frame_rdy);
    end
    send(1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (state !== 3'd2 || frame_rdy !== 1'b0 || agc_rst !== 1'b0) begin
      n_bad++; $display("FAIL hand_ack: got state=%0d rdy=%b agc=%b required 2/0/0", state, frame_rdy, agc_rst);
    end
    send(1'b1, 1'b0, 1'b0, 1'b0);
    waddr = 0;
    send(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL hand_capture: got %0d required 3", state); end
    repeat (8) send(1'b1, 1'b0, 1'b0, 1'b1);
    send(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (frame_rdy !== 1'b1 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL hand_frame2: got rdy=%b pending=%0d required 1/0", frame_rdy, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    send(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      repeat (15) send(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL to_pre%0d: got %0d required 2", k, state); end
      send(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (state !== 3'd1 || drop_cnt !== 16'(k)) begin
        n_bad++; $display("FAIL to_hit%0d: got state=%0d drop=%0d required 1/%0d", k, state, drop_cnt, k);
      end
      repeat (4) send(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL to_resettle%0d: got %0d required 2", k, state); end
    end
    repeat (15) send(1'b1, 1'b0, 1'b0, 1'b0);
    waddr = 0;
    send(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (state !== 3'd3 || drop_cnt !== 16'd3) begin
      n_bad++; $display("FAIL to_peak_wins: got state=%0d drop=%0d required 3/3", state, drop_cnt);
    end
  endtask

  task automatic test_gapped();
    int wr0;
    wr0 = n_wr;
    for (int k = 0; k < 8; k++) begin
      send(1'b1, 1'b0, 1'b0, 1'b1);
      repeat (2) send(1'b0, 1'b1, 1'b0, 1'b0);
    end
    n_cmp++; if (n_wr - wr0 != 8 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL gap_count: got %0d writes pending=%0d required 8/0", n_wr - wr0, exp_q.size());
    end
    n_cmp++; if (state !== 3'd4 || frame_rdy !== 1'b1) begin
      n_bad++; $display("FAIL gap_ready: got state=%0d rdy=%b required 4/1", state, frame_rdy);
    end
  endtask

  task automatic test_abort();
    send(1'b0, 1'b0, 1'b1, 1'b0);
    waddr = 0;
    send(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) send(1'b1, 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    send(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (state !== 3'd0 || agc_rst !== 1'b1 || wr_en !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle: got state=%0d agc=%b wr=%b required 0/1/0", state, agc_rst, wr_en);
    end
    repeat (4) send(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (state !== 3'd0 || frame_rdy !== 1'b0 || drop_cnt !== 16'd3) begin
      n_bad++; $display("FAIL abort_ignore: got state=%0d rdy=%b drop=%0d required 0/0/3", state, frame_rdy, drop_cnt);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    send(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) send(1'b1, 1'b0, 1'b0, 1'b0);
    waddr = 0;
    send(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) send(1'b1, 1'b0, 1'b0, 1'b1);
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (state !== 3'd0 || agc_rst !== 1'b1 || wr_en !== 1'b0 || frame_rdy !== 1'b0) begin
      n_bad++; $display("FAIL arst_ctrl: got state=%0d agc=%b wr=%b rdy=%b required 0/1/0/0", state, agc_rst, wr_en, frame_rdy);
    end
    n_cmp++; if (wr_addr !== '0 || wr_data !== '0 || drop_cnt !== 16'd0) begin
      n_bad++; $display("FAIL arst_data: got addr=%0d data=%h drop=%0d required 0/0/0", wr_addr, wr_data, drop_cnt);
    end
    exp_q.delete();
    tick();
    #2 rstn = 1'b1;
    tick();
    n_cmp++; if (state !== 3'd1 || agc_rst !== 1'b0) begin
      n_bad++; $display("FAIL arst_restart: got state=%0d agc=%b required 1/0", state, agc_rst);
    end
    en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_handoff();
    test_timeout();
    test_gapped();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
